fmap_streamer: RTL

- Producer end of the convolver activation interface: reads a feature map from on-chip SRAM and streams pixels in raster order, inserting zero padding.
- Sits between the activation buffer SRAM and the convolver input (activation_in/en).
- Fully ready/valid backpressured, so the downstream can stall at any cycle without loss or duplication.

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/fmap_out_fifo.sv | 64 ++++++
 rtl/fmap_streamer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared definitions for the CNN activation path.
//   - default pixel width and feature-map geometry used as parameter defaults
//   - FSM state encoding for fmap_streamer
//   - cnt_width(): counter width able to hold 0..n-1 (minimum 1 bit)
package cnn_pkg;

    localparam int PIX_N       = 16;
    localparam int FMAP_W      = 416;
    localparam int FMAP_H      = 416;
    localparam int FMAP_PAD    = 1;
    localparam int FMAP_ADDR_W = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fmap_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmap_out_fifo.sv
// fmap_out_fifo: 2-entry synchronous FIFO holding output beats of fmap_streamer.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO, clears storage)
//   push, push_data   write one entry (caller guarantees space or a same-cycle pop)
//   pop           remove the head entry (caller guarantees non-empty)
//   rd_data       head entry, straight from storage flops
//   count         occupancy 0..2
module fmap_out_fifo #(
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] rd_data,
    output logic [1:0]    count
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;

    // Next-state computation for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // State registers; storage is cleared on reset so the head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/fmap_streamer.sv
// fmap_streamer: reads a W x H feature map from SRAM and streams it in raster
// order over a (W+2*PAD) x (H+2*PAD) padded grid, pad positions reading as 0.
// Ports:
//   clk, rst            clock, synchronous active-high reset (aborts a frame, no done)
//   start, base_addr    launch a frame (only in IDLE); base_addr = address of pixel (0,0)
//   busy, done          frame in progress / one-cycle completion pulse
//   mem_rd_en, mem_addr, mem_rd_data   SRAM read port, data returns one cycle later
//   out_valid, out_ready, out_data, out_last_col, out_last   ready/valid output stream
//   stall_cycles        (only with FMAP_STREAM_STALL_CNT_EN) saturating count of
//                       cycles with out_valid && !out_ready while busy
// Optional feature macro: FMAP_STREAM_STALL_CNT_EN.
module fmap_streamer
    import cnn_pkg::*;
#(
    parameter int N      = PIX_N,
    parameter int W      = FMAP_W,
    parameter int H      = FMAP_H,
    parameter int PAD    = FMAP_PAD,
    parameter int ADDR_W = FMAP_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [N-1:0]      mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic              out_last_col,
    output logic              out_last
`ifdef FMAP_STREAM_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int WP = W + 2 * PAD;
    localparam int HP = H + 2 * PAD;
    localparam int CW = cnt_width(WP);
    localparam int RW = cnt_width(HP);
    localparam logic [CW-1:0] C_LAST = CW'(WP - 1);
    localparam logic [RW-1:0] R_LAST = RW'(HP - 1);

    fmap_state_e       state_q, state_d;
    logic [RW-1:0]     r_q, r_d;
    logic [CW-1:0]     c_q, c_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    // Issue stage: one position in flight while the SRAM read completes.
    logic              stg_valid_q, stg_valid_d;
    logic              stg_pad_q, stg_pad_d;
    logic              stg_lc_q, stg_lc_d;
    logic              stg_last_q, stg_last_d;

    logic [1:0]        fifo_count_s;
    logic [1:0]        occ_s;
    logic              pop_s;
    logic              credit_ok_s;
    logic              issue_s;
    logic              pad_s;
    logic              drain_empty_s;
    logic [N+1:0]      push_data_s;
    logic [N+1:0]      head_s;

    assign pop_s = out_valid && out_ready;
    // Beats held in the FIFO plus the one in the stage; never exceeds 2.
    assign occ_s       = fifo_count_s + {1'b0, stg_valid_q};
    // A pop this cycle frees the slot the stage will push into next cycle.
    assign credit_ok_s = (occ_s < 2'd2) || ((occ_s == 2'd2) && pop_s);
    assign issue_s     = (state_q == RUN) && credit_ok_s;
    assign pad_s       = (int'(r_q) < PAD) || (int'(r_q) >= H + PAD) ||
                         (int'(c_q) < PAD) || (int'(c_q) >= W + PAD);
    // Frame finishes once the FIFO is empty after this cycle's pop.
    assign drain_empty_s = !stg_valid_q &&
                           ((fifo_count_s == 2'd0) || ((fifo_count_s == 2'd1) && pop_s));

    assign mem_rd_en = issue_s && !pad_s;
    assign mem_addr  = ptr_q;

    // FSM, raster counters, address pointer and issue-stage next state.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        c_d         = c_q;
        ptr_d       = ptr_q;
        stg_valid_d = issue_s;
        stg_pad_d   = pad_s;
        stg_lc_d    = (c_q == C_LAST);
        stg_last_d  = (c_q == C_LAST) && (r_q == R_LAST);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    r_d     = '0;
                    c_d     = '0;
                    ptr_d   = base_addr;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (issue_s) begin
                    if (!pad_s) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end else begin
                        ptr_d = ptr_q;
                    end
                    if (c_q == C_LAST) begin
                        c_d = '0;
                        if (r_q == R_LAST) begin
                            state_d = DRAIN;
                        end else begin
                            r_d = r_q + RW'(1);
                        end
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (drain_empty_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and stage registers; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            c_q         <= '0;
            ptr_q       <= '0;
            stg_valid_q <= 1'b0;
            stg_pad_q   <= 1'b0;
            stg_lc_q    <= 1'b0;
            stg_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            c_q         <= c_d;
            ptr_q       <= ptr_d;
            stg_valid_q <= stg_valid_d;
            stg_pad_q   <= stg_pad_d;
            stg_lc_q    <= stg_lc_d;
            stg_last_q  <= stg_last_d;
        end
    end

    assign push_data_s = {(stg_pad_q ? N'(0) : mem_rd_data), stg_lc_q, stg_last_q};

    fmap_out_fifo #(
        .DW (N + 2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (stg_valid_q),
        .push_data (push_data_s),
        .pop       (pop_s),
        .rd_data   (head_s),
        .count     (fifo_count_s)
    );

    assign out_valid    = (fifo_count_s != 2'd0);
    assign out_data     = head_s[N+1:2];
    assign out_last_col = head_s[1];
    assign out_last     = head_s[0];
    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);

`ifdef FMAP_STREAM_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Saturating stall counter, cleared by an accepted start.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start) begin
            stall_d = 32'd0;
        end else if (busy && out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
